mat_mul_stream: RTL and testbench

MAT_MUL_STREAM -- requirements
Module: mat_mul_stream

---
 rtl/mat_mul_stream.sv | 229 ++++++++++++++++++++++
 tb/tb_mat_mul_stream.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mul_stream.sv
// Streaming matrix multiplier: loads an MxK matrix A and a KxN matrix B over
// AXI-Stream style inputs, accumulates C = A*B one inner index per cycle, and
// streams C out row-major through a single-entry register slice.
module mat_mul_stream #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int M      = 2,
  parameter int N      = 2,
  parameter int K_MAX  = 8,
  parameter int KW     = $clog2(K_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_a_tdata,
  input  logic              s_axis_a_tvalid,
  output logic              s_axis_a_tready,
  input  logic              s_axis_a_tlast,
  input  logic [DATA_W-1:0] s_axis_b_tdata,
  input  logic              s_axis_b_tvalid,
  output logic              s_axis_b_tready,
  input  logic              s_axis_b_tlast,
  output logic [ACC_W-1:0]  m_axis_c_tdata,
  output logic              m_axis_c_tvalid,
  input  logic              m_axis_c_tready,
  output logic              m_axis_c_tlast,
  input  logic [KW-1:0]     cfg_k,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Row/column index widths; storage is padded to powers of two so that every
  // counter indexes its array with exactly the right number of bits.
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int MD = 1 << RW;
  localparam int ND = 1 << NW;
  localparam int KD = 1 << KW;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]       state;
  logic [KW-1:0]    k_reg;
  logic [RW-1:0]    a_row;
  logic [KW-1:0]    a_col;
  logic [KW-1:0]    b_row;
  logic [NW-1:0]    b_col;
  logic [KW-1:0]    comp_k;
  logic [RW-1:0]    o_row;
  logic [NW-1:0]    o_col;
  logic             o_all_loaded;
  logic             err_q;
  logic [ACC_W-1:0] c_data;
  logic             c_valid;
  logic             c_last;

  logic signed [DATA_W-1:0] a_mem [MD][KD];
  logic signed [DATA_W-1:0] b_mem [KD][ND];
  logic signed [ACC_W-1:0]  acc   [MD][ND];

  logic a_last_beat;
  logic b_last_beat;
  logic comp_last;
  logic o_last_cell;
  logic c_fire;
  logic c_load;
  logic cfg_bad;

  // Signed product of one A and one B element, sign-extended to accumulator width.
  function automatic logic signed [ACC_W-1:0] mac_term(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] p;
    p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    return ACC_W'(p);
  endfunction

  assign a_last_beat = (a_row == RW'(M - 1)) && (a_col == k_reg - KW'(1));
  assign b_last_beat = (b_row == k_reg - KW'(1)) && (b_col == NW'(N - 1));
  assign comp_last   = (comp_k == k_reg - KW'(1));
  assign o_last_cell = (o_row == RW'(M - 1)) && (o_col == NW'(N - 1));
  assign c_fire      = c_valid && m_axis_c_tready;
  assign c_load      = (state == S_OUTPUT) && !o_all_loaded && (!c_valid || m_axis_c_tready);
  assign cfg_bad     = (cfg_k == '0) || (cfg_k > KW'(K_MAX));

  assign s_axis_a_tready = (state == S_LOAD_A);
  assign s_axis_b_tready = (state == S_LOAD_B);
  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);
  assign err             = err_q;
  assign m_axis_c_tdata  = c_data;
  assign m_axis_c_tvalid = c_valid;
  assign m_axis_c_tlast  = c_last;

  // Job sequencing: beat counters, inner-loop counter, error flag and C output slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      k_reg        <= '0;
      a_row        <= '0;
      a_col        <= '0;
      b_row        <= '0;
      b_col        <= '0;
      comp_k       <= '0;
      o_row        <= '0;
      o_col        <= '0;
      o_all_loaded <= 1'b0;
      err_q        <= 1'b0;
      c_data       <= '0;
      c_valid      <= 1'b0;
      c_last       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k_reg  <= cfg_k;
            err_q  <= 1'b0;
            a_row  <= '0;
            a_col  <= '0;
            b_row  <= '0;
            b_col  <= '0;
            comp_k <= '0;
            if (cfg_bad) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_LOAD_A;
            end
          end
        end
        S_LOAD_A: begin
          if (s_axis_a_tvalid) begin
            if (s_axis_a_tlast != a_last_beat) err_q <= 1'b1;
            if (a_last_beat) begin
              a_row <= '0;
              a_col <= '0;
              state <= S_LOAD_B;
            end else if (a_col == k_reg - KW'(1)) begin
              a_col <= '0;
              a_row <= a_row + RW'(1);
            end else begin
              a_col <= a_col + KW'(1);
            end
          end
        end
        S_LOAD_B: begin
          if (s_axis_b_tvalid) begin
            if (s_axis_b_tlast != b_last_beat) err_q <= 1'b1;
            if (b_last_beat) begin
              b_row <= '0;
              b_col <= '0;
              state <= S_COMPUTE;
            end else if (b_col == NW'(N - 1)) begin
              b_col <= '0;
              b_row <= b_row + KW'(1);
            end else begin
              b_col <= b_col + NW'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (comp_last) begin
            comp_k       <= '0;
            o_row        <= '0;
            o_col        <= '0;
            o_all_loaded <= 1'b0;
            state        <= S_OUTPUT;
          end else begin
            comp_k <= comp_k + KW'(1);
          end
        end
        S_OUTPUT: begin
          if (c_load) begin
            c_data  <= acc[o_row][o_col];
            c_valid <= 1'b1;
            c_last  <= o_last_cell;
            if (o_last_cell) begin
              o_all_loaded <= 1'b1;
            end else if (o_col == NW'(N - 1)) begin
              o_col <= '0;
              o_row <= o_row + RW'(1);
            end else begin
              o_col <= o_col + NW'(1);
            end
          end else if (c_fire) begin
            c_valid <= 1'b0;
          end
          if (c_fire && c_last) begin
            c_last <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          o_all_loaded <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand storage and accumulators; every entry read in a job is written earlier in that job.
  always_ff @(posedge clk) begin
    if (state == S_LOAD_A && s_axis_a_tvalid) a_mem[a_row][a_col] <= s_axis_a_tdata;
    if (state == S_LOAD_B && s_axis_b_tvalid) b_mem[b_row][b_col] <= s_axis_b_tdata;
    if (state == S_LOAD_B && s_axis_b_tvalid && b_last_beat) begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < N; j++) begin
          acc[RW'(i)][NW'(j)] <= '0;
        end
      end
    end else if (state == S_COMPUTE) begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < N; j++) begin
          acc[RW'(i)][NW'(j)] <= acc[RW'(i)][NW'(j)] +
                                 mac_term(a_mem[RW'(i)][comp_k], b_mem[comp_k][NW'(j)]);
        end
      end
    end
  end

endmodule

// File: tb/tb_mat_mul_stream.sv
// Self-checking bench for mat_mul_stream: directed jobs plus randomized jobs
// compared against a plain-arithmetic matrix product reference.
module tb_mat_mul_stream;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;
  localparam int M      = 2;
  localparam int N      = 2;
  localparam int K_MAX  = 8;
  localparam int KW     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] s_axis_a_tdata = '0;
  logic              s_axis_a_tvalid = 1'b0;
  logic              s_axis_a_tready;
  logic              s_axis_a_tlast = 1'b0;
  logic [DATA_W-1:0] s_axis_b_tdata = '0;
  logic              s_axis_b_tvalid = 1'b0;
  logic              s_axis_b_tready;
  logic              s_axis_b_tlast = 1'b0;
  logic [ACC_W-1:0]  m_axis_c_tdata;
  logic              m_axis_c_tvalid;
  logic              m_axis_c_tready = 1'b0;
  logic              m_axis_c_tlast;
  logic [KW-1:0]     cfg_k = '0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic              err;

  mat_mul_stream #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .M(M), .N(N), .K_MAX(K_MAX), .KW(KW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_a_tdata(s_axis_a_tdata), .s_axis_a_tvalid(s_axis_a_tvalid),
    .s_axis_a_tready(s_axis_a_tready), .s_axis_a_tlast(s_axis_a_tlast),
    .s_axis_b_tdata(s_axis_b_tdata), .s_axis_b_tvalid(s_axis_b_tvalid),
    .s_axis_b_tready(s_axis_b_tready), .s_axis_b_tlast(s_axis_b_tlast),
    .m_axis_c_tdata(m_axis_c_tdata), .m_axis_c_tvalid(m_axis_c_tvalid),
    .m_axis_c_tready(m_axis_c_tready), .m_axis_c_tlast(m_axis_c_tlast),
    .cfg_k(cfg_k), .start(start), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  int               a_v [M*K_MAX];
  int               b_v [K_MAX*N];
  logic [ACC_W-1:0] exp_c [M*N];
  logic [ACC_W-1:0] got_c [$];
  logic             got_last [$];
  int               first_lat;
  int               stall_bad;
  bit               timeout;
  bit               done_ok;
  logic             err_start;
  logic             err_end;
  int               t0;

  // Reference: C[i][j] = sum over k of A[i][k]*B[k][j], kept modulo 2^ACC_W.
  function automatic void model(input int k);
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        longint s;
        s = 0;
        for (int kk = 0; kk < k; kk++) s += longint'(a_v[i*k+kk]) * longint'(b_v[kk*N+j]);
        exp_c[i*N+j] = s[ACC_W-1:0];
      end
    end
  endfunction

  function automatic void fill_random(input int k);
    for (int i = 0; i < M*k; i++) a_v[i] = int'($urandom_range(0, 65535)) - 32768;
    for (int i = 0; i < k*N; i++) b_v[i] = int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Runs one job: start, A stream, B stream, then collects C under the chosen
  // tready pattern (0 always, 1 = 1,0,0,1 repeating, 2 random). bad_last >= 0
  // places A tlast on that beat instead of the final one; stop_beats >= 0 returns
  // as soon as that C beat is presented.
  task automatic applyStimulus(input int k, input int bad_last, input int ready_mode,
                               input int stop_beats);
    int g, beat, cidx;
    bit r, prev_stall;
    logic [ACC_W-1:0] prev_data;
    logic prev_last, d1, v1;
    got_c.delete(); got_last.delete();
    first_lat = -1; stall_bad = 0; timeout = 0; done_ok = 0;
    prev_stall = 0; prev_data = '0; prev_last = 0;
    cfg_k = KW'(k); start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b0; err_start = err;
    for (int i = 0; i < M*k; i++) begin
      s_axis_a_tdata  = DATA_W'(a_v[i]);
      s_axis_a_tvalid = 1'b1;
      s_axis_a_tlast  = (bad_last < 0) ? (i == M*k-1) : (i == bad_last);
      g = 0;
      while (s_axis_a_tready !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
      if (g >= 50) timeout = 1;
      @(posedge clk); #1;
    end
    s_axis_a_tvalid = 1'b0; s_axis_a_tlast = 1'b0;
    for (int i = 0; i < k*N; i++) begin
      s_axis_b_tdata  = DATA_W'(b_v[i]);
      s_axis_b_tvalid = 1'b1;
      s_axis_b_tlast  = (i == k*N-1);
      g = 0;
      while (s_axis_b_tready !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
      if (g >= 50) timeout = 1;
      @(posedge clk); #1;
    end
    s_axis_b_tvalid = 1'b0; s_axis_b_tlast = 1'b0;
    beat = 0; g = 0; cidx = 0;
    while (beat < M*N && g < 400) begin
      if (stop_beats >= 0 && beat == stop_beats && m_axis_c_tvalid === 1'b1) return;
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = (cidx % 4 == 0) || (cidx % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      m_axis_c_tready = r;
      if (prev_stall && (m_axis_c_tvalid !== 1'b1 || m_axis_c_tdata !== prev_data ||
                         m_axis_c_tlast !== prev_last)) stall_bad++;
      if (m_axis_c_tvalid === 1'b1 && r) begin
        if (beat == 0) first_lat = cyc + 1 - t0;
        got_c.push_back(m_axis_c_tdata);
        got_last.push_back(m_axis_c_tlast);
        beat++;
      end
      prev_stall = (m_axis_c_tvalid === 1'b1) && !r;
      prev_data  = m_axis_c_tdata;
      prev_last  = m_axis_c_tlast;
      @(posedge clk); #1;
      g++; cidx++;
    end
    m_axis_c_tready = 1'b0;
    if (beat < M*N) begin timeout = 1; return; end
    d1 = done; v1 = m_axis_c_tvalid;
    @(posedge clk); #1;
    done_ok = (d1 === 1'b1) && (v1 === 1'b0) && (done === 1'b0) && (busy === 1'b0);
    err_end = err;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({busy, done, err, m_axis_c_tvalid, m_axis_c_tlast, s_axis_a_tready, s_axis_b_tready} !== 7'b0) begin
      errs++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
               {busy, done, err, m_axis_c_tvalid, m_axis_c_tlast, s_axis_a_tready, s_axis_b_tready});
    end
    checks++;
    if (m_axis_c_tdata !== '0) begin
      errs++; $display("[TB] FAIL reset_tdata: got %0h expected 0", m_axis_c_tdata);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errs++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    logic [ACC_W-1:0] ref_c [4];
    ref_c = '{40'd19, 40'd22, 40'd43, 40'd50};
    a_v[0] = 1; a_v[1] = 2; a_v[2] = 3; a_v[3] = 4;
    b_v[0] = 5; b_v[1] = 6; b_v[2] = 7; b_v[3] = 8;
    applyStimulus(2, -1, 0, -1);
    checks++;
    if (timeout || got_c.size() != 4) begin
      errs++; $display("[TB] FAIL basic_beats: got %0d beats (timeout=%0d) expected 4", got_c.size(), timeout);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got_c[b] !== ref_c[b]) begin
        errs++; $display("[TB] FAIL basic_c%0d: got %0d expected %0d", b, got_c[b], ref_c[b]);
      end
      checks++;
      if (got_last[b] !== (b == 3)) begin
        errs++; $display("[TB] FAIL basic_tlast%0d: got %b expected %b", b, got_last[b], b == 3);
      end
    end
    checks++;
    if (first_lat != M*2 + 2*N + 2 + 2) begin
      errs++; $display("[TB] FAIL basic_latency: got %0d expected %0d", first_lat, M*2 + 2*N + 2 + 2);
    end
    checks++;
    if (!done_ok) begin errs++; $display("[TB] FAIL basic_done: got pulse_ok=%0d expected 1", done_ok); end
    checks++;
    if (err_end !== 1'b0 || err_start !== 1'b0) begin
      errs++; $display("[TB] FAIL basic_err: got start=%b end=%b expected 0 0", err_start, err_end);
    end
  endtask

  task automatic test_backpressure();
    a_v[0] = 1; a_v[1] = 2; a_v[2] = 3; a_v[3] = 4;
    b_v[0] = 5; b_v[1] = 6; b_v[2] = 7; b_v[3] = 8;
    model(2);
    applyStimulus(2, -1, 1, -1);
    checks++;
    if (timeout || got_c.size() != 4) begin
      errs++; $display("[TB] FAIL bp_beats: got %0d beats (timeout=%0d) expected 4", got_c.size(), timeout);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got_c[b] !== exp_c[b] || got_last[b] !== (b == 3)) begin
        errs++; $display("[TB] FAIL bp_c%0d: got %0d/%b expected %0d/%b", b, got_c[b], got_last[b], exp_c[b], b == 3);
      end
    end
    checks++;
    if (stall_bad != 0) begin errs++; $display("[TB] FAIL bp_stable: got %0d unstable stalls expected 0", stall_bad); end
    checks++;
    if (!done_ok) begin errs++; $display("[TB] FAIL bp_done: got pulse_ok=%0d expected 1", done_ok); end
  endtask

  task automatic test_k8();
    logic [ACC_W-1:0] want;
    want = -40'sd262136;
    for (int i = 0; i < M*8; i++) a_v[i] = -1;
    for (int i = 0; i < 8*N; i++) b_v[i] = 32767;
    applyStimulus(8, -1, 0, -1);
    checks++;
    if (timeout || got_c.size() != 4) begin
      errs++; $display("[TB] FAIL k8_beats: got %0d beats (timeout=%0d) expected 4", got_c.size(), timeout);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got_c[b] !== want) begin errs++; $display("[TB] FAIL k8_c%0d: got %0h expected %0h", b, got_c[b], want); end
    end
    checks++;
    if (first_lat != 42) begin errs++; $display("[TB] FAIL k8_latency: got %0d expected 42", first_lat); end
  endtask

  task automatic test_bad_cfg();
    int bad_k [2];
    bad_k = '{0, 9};
    foreach (bad_k[n]) begin
      cfg_k = KW'(bad_k[n]); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({err, done, busy, s_axis_a_tready, s_axis_b_tready} !== 5'b11100) begin
        errs++; $display("[TB] FAIL badcfg%0d_first: got err,done,busy,ra,rb=%b expected 11100",
                         bad_k[n], {err, done, busy, s_axis_a_tready, s_axis_b_tready});
      end
      @(posedge clk); #1;
      checks++;
      if ({err, done, busy, s_axis_a_tready, s_axis_b_tready} !== 5'b10000) begin
        errs++; $display("[TB] FAIL badcfg%0d_next: got err,done,busy,ra,rb=%b expected 10000",
                         bad_k[n], {err, done, busy, s_axis_a_tready, s_axis_b_tready});
      end
    end
    fill_random(1);
    model(1);
    applyStimulus(1, -1, 0, -1);
    checks++;
    if (err_start !== 1'b0 || err_end !== 1'b0) begin
      errs++; $display("[TB] FAIL badcfg_clear: got start=%b end=%b expected 0 0", err_start, err_end);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got_c[b] !== exp_c[b]) begin errs++; $display("[TB] FAIL badcfg_c%0d: got %0h expected %0h", b, got_c[b], exp_c[b]); end
    end
  endtask

  task automatic test_tlast_err();
    fill_random(2);
    model(2);
    applyStimulus(2, 1, 0, -1);
    checks++;
    if (timeout || got_c.size() != 4) begin
      errs++; $display("[TB] FAIL tlast_beats: got %0d beats (timeout=%0d) expected 4", got_c.size(), timeout);
    end
    checks++;
    if (err_end !== 1'b1) begin errs++; $display("[TB] FAIL tlast_err: got %b expected 1", err_end); end
    checks++;
    if (first_lat != 12) begin errs++; $display("[TB] FAIL tlast_latency: got %0d expected 12", first_lat); end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got_c[b] !== exp_c[b]) begin errs++; $display("[TB] FAIL tlast_c%0d: got %0h expected %0h", b, got_c[b], exp_c[b]); end
    end
    checks++;
    if (!done_ok) begin errs++; $display("[TB] FAIL tlast_done: got pulse_ok=%0d expected 1", done_ok); end
  endtask

  task automatic test_reset_mid();
    fill_random(3);
    model(3);
    applyStimulus(3, -1, 0, 2);
    checks++;
    if (got_c.size() != 2 || got_c[0] !== exp_c[0] || got_c[1] !== exp_c[1]) begin
      errs++; $display("[TB] FAIL midrst_pre: got %0d beats expected 2 correct beats", got_c.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, m_axis_c_tvalid, m_axis_c_tlast, s_axis_a_tready, s_axis_b_tready} !== 6'b0 ||
        m_axis_c_tdata !== '0) begin
      errs++; $display("[TB] FAIL midrst_outputs: got ctrl=%b tdata=%0h expected 0",
                       {busy, done, m_axis_c_tvalid, m_axis_c_tlast, s_axis_a_tready, s_axis_b_tready}, m_axis_c_tdata);
    end
    m_axis_c_tready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || m_axis_c_tvalid !== 1'b0) begin
      errs++; $display("[TB] FAIL midrst_idle: got busy=%b tvalid=%b expected 0 0", busy, m_axis_c_tvalid);
    end
    fill_random(2);
    model(2);
    applyStimulus(2, -1, 2, -1);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got_c[b] !== exp_c[b]) begin errs++; $display("[TB] FAIL midrst_next_c%0d: got %0h expected %0h", b, got_c[b], exp_c[b]); end
    end
    checks++;
    if (!done_ok) begin errs++; $display("[TB] FAIL midrst_done: got pulse_ok=%0d expected 1", done_ok); end
  endtask

  task automatic test_random();
    int k, mode;
    for (int job = 0; job < 5; job++) begin
      k = int'($urandom_range(1, K_MAX));
      mode = int'($urandom_range(0, 2));
      fill_random(k);
      model(k);
      applyStimulus(k, -1, mode, -1);
      checks++;
      if (timeout || got_c.size() != 4) begin
        errs++; $display("[TB] FAIL rand%0d_beats: got %0d beats (timeout=%0d) expected 4", job, got_c.size(), timeout);
      end
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (got_c[b] !== exp_c[b] || got_last[b] !== (b == 3)) begin
          errs++; $display("[TB] FAIL rand%0d_c%0d: got %0h/%b expected %0h/%b (k=%0d)",
                           job, b, got_c[b], got_last[b], exp_c[b], b == 3, k);
        end
      end
      checks++;
      if (!done_ok || err_end !== 1'b0 || stall_bad != 0) begin
        errs++; $display("[TB] FAIL rand%0d_status: got done_ok=%0d err=%b stalls=%0d expected 1 0 0",
                         job, done_ok, err_end, stall_bad);
      end
      if (mode == 0) begin
        checks++;
        if (first_lat != M*k + k*N + k + 2) begin
          errs++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", job, first_lat, M*k + k*N + k + 2);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_k8();
    test_bad_cfg();
    test_tlast_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errs);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
